// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory command encoding, read-return owner and
// the default fetch-starvation bound for the memory port arbiter.
package cpu_pkg;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        F    = 2'd1,
        D    = 2'd2
    } owner_e;

    localparam int DEF_MAX_STREAK = 3;

endpackage : cpu_pkg

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported Memory between fetch (F) and load/store (D).
// D has priority; a streak counter forces an F grant after MAX_STREAK D wins.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int MAX_STREAK = DEF_MAX_STREAK,
    parameter int AW         = 16,
    parameter int DW         = 16
) (
    input  logic          clk,
    input  logic          nRESET,

    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [DW-1:0] f_rdata,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,

    output logic          mem_rw,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int SW = $clog2(MAX_STREAK + 1);

    logic [SW-1:0] streak;
    logic          streak_full;
    owner_e        rd_owner;
    logic [DW-1:0] f_rdata_p1;
    logic [DW-1:0] d_rdata_p1;

    assign streak_full = (streak == SW'(MAX_STREAK));

    // Grant and command mux: purely combinational so they follow requests even in reset
    always_comb begin
        d_gnt     = 1'b0;
        f_gnt     = 1'b0;
        mem_rw    = READ;
        mem_addr  = '0;
        mem_wdata = '0;

        if (d_req && !(f_req && streak_full)) begin
            d_gnt = 1'b1;
        end else if (f_req) begin
            f_gnt = 1'b1;
        end

        if (d_gnt) begin
            mem_rw    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (f_gnt) begin
            mem_addr  = f_addr;
        end
    end

    // Streak only counts D wins that actually made F wait
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            streak <= '0;
        end else if (!f_req || f_gnt) begin
            streak <= '0;
        end else if (d_gnt && !streak_full) begin
            streak <= streak + 1'b1;
        end
    end

    // Grant stage -> return stage: remember who owns next cycle's read data
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            rd_owner <= NONE;
        end else if (f_gnt) begin
            rd_owner <= F;
        end else if (d_gnt && (d_we == READ)) begin
            rd_owner <= D;
        end else begin
            rd_owner <= NONE;
        end
    end

    // Return stage: capture the delivered word so the port keeps showing it afterwards
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            f_rdata_p1 <= '0;
            d_rdata_p1 <= '0;
        end else begin
            if (rd_owner == F) f_rdata_p1 <= mem_rdata;
            if (rd_owner == D) d_rdata_p1 <= mem_rdata;
        end
    end

    assign f_rvalid = (rd_owner == F);
    assign d_rvalid = (rd_owner == D);
    assign f_rdata  = f_rvalid ? mem_rdata : f_rdata_p1;
    assign d_rdata  = d_rvalid ? mem_rdata : d_rdata_p1;

endmodule : mem_port_arbiter

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the CPU's single-ported `Memory` between instruction fetch (port F) and load/store (port D). It sits between the fetch/PC logic, the load/store path and the one `Memory` instance. It issues at most one memory command per cycle and routes synchronous read data back to the owner one cycle later. D has priority, and a streak counter guarantees fetch forward progress.

## Interface
- `MAX_STREAK`, 3: maximum number of consecutive D grants while F is requesting; the next grant goes to F.
- `AW`, 16: address width.
- `DW`, 16: data width.

- `clk` in 1: the single clock; all state changes on its rising edge.
- `nRESET` in 1: reset, asynchronous, active-low.
- `f_req` in 1: fetch request; a level held until granted.
- `f_addr` in AW: fetch address.
- `f_gnt` out 1: fetch command accepted this cycle (combinational).
- `f_rvalid` out 1: `f_rdata` valid (registered).
- `f_rdata` out DW: fetched instruction.
- `d_req` in 1: data request; a level held until granted.
- `d_we` in 1: 1 = write, 0 = read.
- `d_addr` in AW: data address.
- `d_wdata` in DW: store data.
- `d_gnt` out 1: data command accepted this cycle (combinational).
- `d_rvalid` out 1: `d_rdata` valid (registered; reads only).
- `d_rdata` out DW: load data.
- `mem_rw` out 1: `READ` (0) or `WRITE` (1) to `Memory`.
- `mem_addr` out AW: memory address.
- `mem_wdata` out DW: memory write data.
- `mem_rdata` in DW: memory read data, valid the cycle after a READ command.

## Operation
- Arbitration is combinational on the current `f_req`/`d_req`. At most one of `f_gnt`/`d_gnt` is high in a cycle.
- Only D requesting: D is granted. Only F requesting: F is granted. Neither requesting: no grant, `mem_rw`=READ, `mem_addr`=0, `mem_wdata`=0, no rvalid next cycle.
- Both requesting: D wins unless `streak` == `MAX_STREAK`, in which case F wins.
- `streak` counter, width clog2(MAX_STREAK+1):
  - increments on a D grant while `f_req`=1, saturating at MAX_STREAK;
  - clears on any F grant;
  - clears on any cycle with `f_req`=0.
- Granted command drives `mem_*` in the same cycle:
  - F: `mem_rw`=READ, `mem_addr`=`f_addr`.
  - D: `mem_rw`=`d_we`, `mem_addr`=`d_addr`, `mem_wdata`=`d_wdata`.
- Read return tracking: the registered `rd_owner` is one of NONE/F/D and is set at the edge ending the grant cycle. A D write sets NONE. In the following cycle the owner's rvalid is 1 and its rdata = `mem_rdata`. The other port's rdata is held at its last value.
- Addresses pass through unchanged; alignment is the requester's responsibility.
- Back-to-back grants are allowed every cycle (full throughput). A read return and a new grant can occur in the same cycle.

## Timing
- Reset (async on `nRESET` low) sets:
  - `streak`=0, `rd_owner`=NONE;
  - `f_rvalid`=`d_rvalid`=0, `f_rdata`=`d_rdata`=0.
- The combinational outputs (`f_gnt`, `d_gnt`, `mem_*`) follow the request inputs even during reset.
- Read latency: grant in cycle t gives rvalid in cycle t+1. Write completes at the edge ending cycle t.
- Reset asserted between a grant and its return discards the return: no rvalid after reset.
- F starvation bound: with `d_req` held at 1, F is granted within MAX_STREAK+1 cycles of raising `f_req`.
- A requester that drops `req` before a grant is simply not served. No request state is kept in the arbiter.

## Structure
- Shared package `cpu_pkg`:
  - `READ`=1'b0, `WRITE`=1'b1 (same meaning as the existing defines);
  - owner enum NONE/F/D (2 bits);
  - default `MAX_STREAK`.
- Single flat module. No sub-module; the streak counter and owner register are small enough to stay inline.

## Test plan
- Reset, then `f_req`=1, `f_addr`=0x0004, `mem_rdata`=0x1234 returned -> `f_gnt`=1 in cycle t; `f_rvalid`=1 and `f_rdata`=0x1234 in t+1; `d_rvalid`=0.
- Only D: `d_we`=1, `d_addr`=0x0100, `d_wdata`=0xBEEF -> `d_gnt`=1, `mem_rw`=1, `mem_addr`=0x0100, `mem_wdata`=0xBEEF; no rvalid next cycle.
- `f_req` and `d_req` both held, MAX_STREAK=3 -> grant order D,D,D,F,D,D,D,F.
- Alternating D read 0x0200 and F read 0x0006 on consecutive cycles -> each return goes to the correct port with the matching data. Never both rvalids in one cycle.
- `nRESET` pulsed low in the cycle after a D read grant -> `d_rvalid` stays 0, `streak`=0, and normal arbitration resumes after release.
- Idle (no requests) -> `mem_rw`=0, `mem_addr`=0, both gnt=0, `streak` stays 0.
